hazard_run_ctrl: RTL

Hazard and run-control unit for the 5-stage RV32 pipeline datapath. It produces the forwarding selects and the stall and flush controls (StallF, StallD, FlushD, FlushE) from the stage register/regwrite taps. It also sequences a debug halt / single-step / resume flow that drains the pipeline to an empty state. Two free-running event counters expose load-use stall and branch/jump redirect counts to the testbench.

---
 rtl/hazard_run_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hazard_run_ctrl.sv
//------------------------------------------------------------------------------
// hazard_run_ctrl : forwarding, stall/flush and debug halt/step control for a
//                   5-stage RV32 pipeline, with load-use and redirect counters.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_run_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             resultsrce_0,
  input  logic             pcsrce,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             halt_req_i,
  input  logic             step_i,
  input  logic             resume_i,
  input  logic             cnt_clr_i,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halted_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_DRAIN  = 2'b01,
    S_HALTED = 2'b10,
    S_STEP   = 2'b11
  } state_e;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        drain_q, drain_d;
  logic              halted_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              lw_stall;
  logic              freeze;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(rs1_e);
  assign ForwardBE = fwd_sel(rs2_e);

  assign lw_stall = resultsrce_0 && (rd_e != 5'd0) && ((rd_e == rs1d) || (rd_e == rs2d));
  assign freeze   = (state_q == S_DRAIN) || (state_q == S_HALTED);

  // A redirect must win over a stall so the IF/ID flush is not masked.
  assign StallF = (lw_stall || freeze) && !pcsrce;
  assign StallD = StallF;
  assign FlushD = pcsrce;
  assign FlushE = lw_stall || pcsrce || freeze;

  assign halted_o    = halted_q;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      S_RUN: begin
        if (halt_req_i && !lw_stall) begin
          state_d = S_DRAIN;
          drain_d = 3'd0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == DRAIN_LAST) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (resume_i)    state_d = S_RUN;
        else if (step_i) state_d = S_STEP;
      end
      S_STEP: begin
        // A load-use hazard means the stepped instruction has not issued yet.
        if (!lw_stall) begin
          state_d = S_DRAIN;
          drain_d = 3'd0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (lw_stall) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (pcsrce)   flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      drain_q     <= 3'd0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      halted_q    <= (state_d == S_HALTED);
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

`default_nettype wire
